// File: rtl/lbp_host_if_if.sv
// rtl/lbp_host_if_if.sv - LBP engine gray-read / result-write bus between engine (master) and host (slave)
interface lbp_host_if_if #(
  parameter int AW = 14
);
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_host_if.sv
// rtl/lbp_host_if.sv - host image store and result capture for the LBP engine
// Optional protocol checking (sticky err) is built only when LBP_WR_CHECK_EN is defined.
module lbp_host_if #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  lbp_host_if_if.slave  eng,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] wr_count,
  output logic          done,
  output logic          err
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [AW-1:0] LD_LAST = AW'(NPIX - 1);

  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} state_t;

  state_t          state;
  logic [AW-1:0]   ld_cnt;
  logic [7:0]      gray_mem [NPIX];
  logic [7:0]      res_mem  [NPIX];
  logic [NPIX-1:0] written;
  logic            gray_ready_q;
  logic            ld_acc;
  logic            wr_acc;

  assign ld_acc = (state == S_LOAD) && ld_valid;
  assign wr_acc = (state == S_SERVE) && eng.lbp_valid;

  assign eng.gray_ready = gray_ready_q;
  assign eng.gray_data  = (gray_ready_q && eng.gray_req) ? gray_mem[eng.gray_addr] : 8'd0;

  // Memory arrays carry no reset; the written bitmap masks stale results.
  always_ff @(posedge clk) begin
    if (ld_acc)
      gray_mem[ld_cnt] <= ld_data;
    if (wr_acc)
      res_mem[eng.lbp_addr] <= eng.lbp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_LOAD;
      ld_cnt       <= '0;
      wr_count     <= '0;
      written      <= '0;
      ld_ready     <= 1'b1;
      gray_ready_q <= 1'b0;
      done         <= 1'b0;
      rd_data      <= 8'd0;
    end else begin
      rd_data <= written[rd_addr] ? res_mem[rd_addr] : 8'd0;
      case (state)
        S_LOAD: begin
          if (ld_valid) begin
            if (ld_cnt == LD_LAST) begin
              ld_cnt       <= '0;
              state        <= S_SERVE;
              ld_ready     <= 1'b0;
              gray_ready_q <= 1'b1;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        S_SERVE: begin
          if (eng.lbp_valid) begin
            written[eng.lbp_addr] <= 1'b1;
            if (wr_count != '1)
              wr_count <= wr_count + 1'b1;
          end
          if (eng.finish) begin
            state        <= S_DONE;
            gray_ready_q <= 1'b0;
            done         <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state        <= S_LOAD;
          ld_ready     <= 1'b1;
          gray_ready_q <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

`ifdef LBP_WR_CHECK_EN
  localparam logic [AW-1:0] INTERIOR = AW'((IMG_W - 2) * (IMG_H - 2));

  int            pix;
  logic          border;
  logic [AW-1:0] cnt_after;
  logic          err_hit;

  // Finish is judged against the count including a write on the same edge.
  always_comb begin
    pix       = int'(eng.lbp_addr);
    border    = (pix < IMG_W) || (pix >= (IMG_H - 1) * IMG_W) ||
                (pix % IMG_W == 0) || (pix % IMG_W == IMG_W - 1);
    cnt_after = wr_count + AW'(wr_acc && (wr_count != '1));
    err_hit   = (wr_acc && (border || written[eng.lbp_addr])) ||
                (eng.lbp_valid && (state != S_SERVE)) ||
                (eng.gray_req && (state == S_LOAD)) ||
                ((state == S_SERVE) && eng.finish && (cnt_after != INTERIOR));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (err_hit)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lbp_host_if.sv
// tb/tb_lbp_host_if.sv - scoreboard bench for lbp_host_if (LBP_WR_CHECK_EN cases when defined)
module tb_lbp_host_if;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] wr_count;
  logic          done;
  logic          err;

  lbp_host_if_if #(.AW(AW)) eng ();

  lbp_host_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .eng      (eng),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_count (wr_count),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_res [NPIX];
  bit         exp_wr  [NPIX];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ld_valid      = 1'b0;
    ld_data       = 8'd0;
    rd_addr       = '0;
    eng.gray_req  = 1'b0;
    eng.gray_addr = '0;
    eng.lbp_valid = 1'b0;
    eng.lbp_addr  = '0;
    eng.lbp_data  = 8'd0;
    eng.finish    = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < NPIX; i++) exp_wr[i] = 1'b0;
  endtask

  task automatic load_pixels(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(first + i);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b exp 1", ld_ready); end
    checks++; if (eng.gray_ready !== 1'b0) begin errors++; $display("FAIL reset_gray_ready got %b exp 0", eng.gray_ready); end
    checks++; if (eng.gray_data !== 8'd0) begin errors++; $display("FAIL reset_gray_data got %h exp 00", eng.gray_data); end
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if (wr_count !== '0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_load;
    load_pixels(0, 5000);
    reset = 1'b0;
    tick();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL midload_ld_ready got %b exp 1", ld_ready); end
    checks++; if (eng.gray_ready !== 1'b0) begin errors++; $display("FAIL midload_gray_ready got %b exp 0", eng.gray_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load;
    load_pixels(0, NPIX - 1);
    checks++; if (eng.gray_ready !== 1'b0) begin errors++; $display("FAIL load_early_ready got %b exp 0", eng.gray_ready); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ld_ready got %b exp 1", ld_ready); end
    load_pixels(NPIX - 1, 1);
    checks++; if (eng.gray_ready !== 1'b1) begin errors++; $display("FAIL load_gray_ready got %b exp 1", eng.gray_ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL load_ld_ready_off got %b exp 0", ld_ready); end
  endtask

  task automatic test_gray_read;
    int addrs [8];
    logic [7:0] e;
    addrs = '{129, 0, NPIX - 1, 255, 256, 4660, 8191, 12345};
    for (int i = 0; i < 8; i++) begin
      eng.gray_req  = 1'b1;
      eng.gray_addr = AW'(addrs[i]);
      sb.push_back(8'(addrs[i]));
      #1;
      e = sb.pop_front();
      checks++; if (eng.gray_data !== e) begin errors++; $display("FAIL gray_read addr %0d got %h exp %h", addrs[i], eng.gray_data, e); end
      tick();
    end
    eng.gray_req  = 1'b0;
    eng.gray_addr = AW'(129);
    sb.push_back(8'd0);
    #1;
    e = sb.pop_front();
    checks++; if (eng.gray_data !== e) begin errors++; $display("FAIL gray_noreq got %h exp %h", eng.gray_data, e); end
    tick();
  endtask

  task automatic test_result_write;
    logic [7:0] e;
    eng.lbp_valid = 1'b1;
    eng.lbp_addr  = AW'(129);
    eng.lbp_data  = 8'hA5;
    exp_res[129]  = 8'hA5;
    exp_wr[129]   = 1'b1;
    tick();
    eng.lbp_valid = 1'b0;
    checks++; if (wr_count !== AW'(1)) begin errors++; $display("FAIL wr_count_one got %0d exp 1", wr_count); end
    rd_addr = AW'(129);
    sb.push_back(8'hA5);
    tick();
    e = sb.pop_front();
    checks++; if (rd_data !== e) begin errors++; $display("FAIL readback_129 got %h exp %h", rd_data, e); end
    rd_addr = AW'(130);
    sb.push_back(8'h00);
    tick();
    e = sb.pop_front();
    checks++; if (rd_data !== e) begin errors++; $display("FAIL readback_130 got %h exp %h", rd_data, e); end
  endtask

  task automatic test_full_run;
    int a;
    logic [7:0] e;
    for (int r = 1; r < IMG_H - 1; r++) begin
      for (int c = 1; c < IMG_W - 1; c++) begin
        a = r * IMG_W + c;
        if (a != 129) begin
          eng.lbp_valid = 1'b1;
          eng.lbp_addr  = AW'(a);
          eng.lbp_data  = 8'(a) ^ 8'h3C;
          eng.finish    = (r == IMG_H - 2) && (c == IMG_W - 2);
          exp_res[a]    = 8'(a) ^ 8'h3C;
          exp_wr[a]     = 1'b1;
          tick();
        end
      end
    end
    eng.lbp_valid = 1'b0;
    eng.finish    = 1'b0;
    eng.gray_req  = 1'b1;
    eng.gray_addr = AW'(129);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b exp 1", done); end
    checks++; if (wr_count !== AW'((IMG_W - 2) * (IMG_H - 2))) begin errors++; $display("FAIL full_wr_count got %0d exp %0d", wr_count, (IMG_W - 2) * (IMG_H - 2)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err got %b exp 0", err); end
    checks++; if (eng.gray_ready !== 1'b0) begin errors++; $display("FAIL done_gray_ready got %b exp 0", eng.gray_ready); end
    checks++; if (eng.gray_data !== 8'd0) begin errors++; $display("FAIL done_gray_data got %h exp 00", eng.gray_data); end
    eng.gray_req = 1'b0;
    // Writes and loads in S_DONE must be ignored.
    eng.lbp_valid = 1'b1;
    eng.lbp_addr  = AW'(5);
    eng.lbp_data  = 8'hFF;
    ld_valid      = 1'b1;
    tick();
    eng.lbp_valid = 1'b0;
    ld_valid      = 1'b0;
    checks++; if (wr_count !== AW'((IMG_W - 2) * (IMG_H - 2))) begin errors++; $display("FAIL done_ignore_wr got %0d exp %0d", wr_count, (IMG_W - 2) * (IMG_H - 2)); end
    checks++; if (done !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL done_hold got done %b ld_ready %b exp 1 0", done, ld_ready); end
    for (int i = 0; i < NPIX + 14; i += 7) begin
      a = (i < NPIX) ? i : ((i < NPIX + 7) ? 16254 : 5);
      rd_addr = AW'(a);
      sb.push_back(exp_wr[a] ? exp_res[a] : 8'd0);
      tick();
      e = sb.pop_front();
      checks++; if (rd_data !== e) begin errors++; $display("FAIL readback addr %0d got %h exp %h", a, rd_data, e); end
    end
  endtask

  task automatic test_reset_after_done;
    logic [7:0] e;
    pulse_reset();
    checks++; if (done !== 1'b0 || wr_count !== '0 || ld_ready !== 1'b1) begin errors++; $display("FAIL post_reset got done %b cnt %0d ld_ready %b exp 0 0 1", done, wr_count, ld_ready); end
    rd_addr = AW'(129);
    sb.push_back(8'd0);
    tick();
    e = sb.pop_front();
    checks++; if (rd_data !== e) begin errors++; $display("FAIL stale_masked got %h exp %h", rd_data, e); end
  endtask

`ifdef LBP_WR_CHECK_EN
  task automatic test_checks;
    for (int k = 0; k < 3; k++) begin
      pulse_reset();
      load_pixels(0, NPIX);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk%0d_pre got %b exp 0", k, err); end
      if (k == 0) begin
        eng.lbp_valid = 1'b1; eng.lbp_addr = '0; eng.lbp_data = 8'h11;
        tick();
      end else if (k == 1) begin
        eng.lbp_valid = 1'b1; eng.lbp_addr = AW'(129); eng.lbp_data = 8'h22;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk1_first got %b exp 0", err); end
        tick();
      end else begin
        for (int j = 0; j < 10; j++) begin
          eng.lbp_valid = 1'b1; eng.lbp_addr = AW'(129 + j); eng.lbp_data = 8'(j);
          tick();
        end
        eng.lbp_valid = 1'b0;
        eng.finish    = 1'b1;
        tick();
      end
      eng.lbp_valid = 1'b0;
      eng.finish    = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk%0d_err got %b exp 1", k, err); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_reset_mid_load();
    test_load();
    test_gray_read();
    test_result_write();
    test_full_run();
    test_reset_after_done();
`ifdef LBP_WR_CHECK_EN
    test_checks();
`endif
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
